// File: rtl/softmax_pkg.sv
// softmax_pkg: shared FSM state type and saturation helper for softmax_backward.
// Contents: state_t (IDLE, DOT, SCALE, FINISH); sat() clamps to a w-bit signed range.
package softmax_pkg;
    typedef enum logic [1:0] {IDLE, DOT, SCALE, FINISH} state_t;
    // Clamp a sign-extended value to the signed range of a w-bit word (w <= 63);
    // callers size-cast the result down to w bits.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction
endpackage

// File: rtl/softmax_backward_if.sv
// softmax_backward_if: request/response bundle for the softmax backward engine.
// Ports: start, y_data[], grad_in[] (master -> slave); grad_out[], done, busy (slave -> master).
interface softmax_backward_if #(
    parameter int WIDTH     = 16,
    parameter int DIMENSION = 10
);
    logic                    start;
    logic signed [WIDTH-1:0] y_data   [DIMENSION];
    logic signed [WIDTH-1:0] grad_in  [DIMENSION];
    logic signed [WIDTH-1:0] grad_out [DIMENSION];
    logic                    done;
    logic                    busy;
    modport master (output start, y_data, grad_in, input grad_out, done, busy);
    modport slave  (input start, y_data, grad_in, output grad_out, done, busy);
endinterface

// File: rtl/fxp_mul.sv
// fxp_mul: signed fixed-point multiply, product shifted right by FIXED_POINT_INDEX.
// Ports: a, b (WIDTH operands); wide (full 2*WIDTH shifted product); narrow (wide saturated to WIDTH).
module fxp_mul import softmax_pkg::*; #(
    parameter int WIDTH             = 16,
    parameter int FIXED_POINT_INDEX = 8
) (
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] wide,
    output logic signed [WIDTH-1:0]   narrow
);
    localparam int PW = 2 * WIDTH;
    always_comb begin
        wide   = (PW'(a) * PW'(b)) >>> FIXED_POINT_INDEX;
        narrow = WIDTH'(sat(64'(wide), WIDTH));
    end
endmodule

// File: rtl/softmax_backward.sv
// softmax_backward: sequential dL/dx = y * (g - sum(y*g)) over a DIMENSION-element vector.
// Ports: clk, reset (async, active-high); bus (slave): start, y_data, grad_in, grad_out, done, busy.
module softmax_backward import softmax_pkg::*; #(
    parameter int WIDTH             = 16,
    parameter int DIMENSION         = 10,
    parameter int FIXED_POINT_INDEX = 8
) (
    input logic               clk,
    input logic               reset,
    softmax_backward_if.slave bus
);
    localparam int IW = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
    localparam int AW = WIDTH + 8;
    localparam logic [IW-1:0] LAST = IW'(DIMENSION - 1);

    state_t                   state, state_next;
    logic [IW-1:0]            idx;
    logic signed [AW-1:0]     acc, acc_next;
    logic signed [WIDTH-1:0]  s;
    logic signed [WIDTH-1:0]  y_r    [DIMENSION];
    logic signed [WIDTH-1:0]  g_r    [DIMENSION];
    logic signed [WIDTH-1:0]  grad_r [DIMENSION];
    logic signed [WIDTH:0]    d;
    logic signed [WIDTH-1:0]  mul_b, mul_narrow;
    logic signed [2*WIDTH-1:0] mul_wide;
    logic                     done_r, in_dot, in_scale, last;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_next;

    always_comb
        state_next = (state == IDLE)  ? (bus.start ? DOT : IDLE) :
                     (state == DOT)   ? (last ? SCALE : DOT) :
                     (state == SCALE) ? (last ? FINISH : SCALE) : IDLE;

    always_comb begin
        bus.busy = state != IDLE;
        in_dot   = state == DOT;
        in_scale = state == SCALE;
        last     = idx == LAST;
    end

    // The single multiplier computes y*g during DOT and y*(g-s) during SCALE.
    always_comb begin
        d        = {g_r[idx][WIDTH-1], g_r[idx]} - {s[WIDTH-1], s};
        mul_b    = in_dot ? g_r[idx] : WIDTH'(sat(64'(d), WIDTH));
        acc_next = AW'(64'(acc) + 64'(mul_wide));
    end

    fxp_mul #(.WIDTH(WIDTH), .FIXED_POINT_INDEX(FIXED_POINT_INDEX)) u_mul (
        .a      (y_r[idx]),
        .b      (mul_b),
        .wide   (mul_wide),
        .narrow (mul_narrow)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx    <= '0;
            acc    <= '0;
            s      <= '0;
            done_r <= 1'b0;
            for (int i = 0; i < DIMENSION; i++) begin
                y_r[i]    <= '0;
                g_r[i]    <= '0;
                grad_r[i] <= '0;
            end
        end else begin
            done_r <= state == FINISH;
            if (state == IDLE && bus.start) begin
                y_r <= bus.y_data;
                g_r <= bus.grad_in;
                acc <= '0;
                idx <= '0;
            end
            if (in_dot) acc <= acc_next;
            // s takes the final sum, including the last product, as DOT ends.
            if (in_dot && last) s <= WIDTH'(sat(64'(acc_next), WIDTH));
            if (in_scale) grad_r[idx] <= mul_narrow;
            if (in_dot || in_scale) idx <= last ? '0 : idx + 1'b1;
        end
    end

    assign bus.done     = done_r;
    assign bus.grad_out = grad_r;
endmodule

// File: doc/softmax_backward.md
SOFTMAX_BACKWARD -- requirements
Module: softmax_backward

Interface
REQ-001 Parameter WIDTH, default 16: bit width of every signed fixed-point data element.
REQ-002 Parameter DIMENSION, default 10: number of vector elements.
REQ-003 Parameter FIXED_POINT_INDEX, default 8: number of fraction bits (1.0 = 2^FIXED_POINT_INDEX).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a new gradient computation; sampled only in IDLE.
REQ-007 y_data  input  signed [WIDTH-1:0] x DIMENSION  softmax forward output y.
REQ-008 grad_in  input  signed [WIDTH-1:0] x DIMENSION  upstream gradient g = dL/dy.
REQ-009 grad_out  output  signed [WIDTH-1:0] x DIMENSION  gradient dL/dx.
REQ-010 done  output  1  one-cycle pulse when grad_out is complete.
REQ-011 busy  output  1  high while a computation is in progress.

Function
REQ-012 Computation: s = sum_j (y_j*g_j); grad_out[i] = y_i*(g_i - s), all in Q(WIDTH-FIXED_POINT_INDEX).(FIXED_POINT_INDEX).
REQ-013 FSM states IDLE, DOT, SCALE, FINISH; IDLE->DOT on start; DOT->SCALE after DIMENSION cycles; SCALE->FINISH after DIMENSION cycles; FINISH->IDLE unconditionally.
REQ-014 On the edge accepting start: y_data and grad_in latched into internal registers, accumulator and index cleared, busy set to 1; inputs may change afterwards without effect.
REQ-015 start sampled while busy is high shall be ignored.
REQ-016 DOT: one element per cycle, index 0..DIMENSION-1; product 2*WIDTH bits, arithmetic right shift by FIXED_POINT_INDEX, added to a WIDTH+8-bit signed accumulator.
REQ-017 On leaving DOT, s = accumulator saturated to WIDTH bits (max 2^(WIDTH-1)-1, min -2^(WIDTH-1)).
REQ-018 SCALE: one element per cycle; d = g_i - s computed in WIDTH+1 bits, saturated to WIDTH; grad_out[i] = saturate_WIDTH((y_i*d) >>> FIXED_POINT_INDEX), written at that edge.
REQ-019 grad_out elements hold their values outside SCALE writes.
REQ-020 Latency: start sampled at edge 0 -> done=1 and busy=0 after edge 2*DIMENSION+1; done=0 after edge 2*DIMENSION+2.
REQ-021 done is high for exactly one cycle per accepted start.
REQ-022 start high during the done cycle is accepted at the next edge (back-to-back throughput = one result per 2*DIMENSION+2 cycles).
REQ-023 All shifts are arithmetic (truncation toward negative infinity); no rounding.

Reset
REQ-024 reset high immediately forces state IDLE, busy=0, done=0, all grad_out elements=0, accumulator and index=0, in any state.
REQ-025 Reset asserted mid-computation abandons it; no done pulse is produced for it.
REQ-026 After reset deasserts, the first start is handled as in REQ-014.

Structure
REQ-027 Shared package softmax_pkg holds the state typedef (IDLE, DOT, SCALE, FINISH) and the saturation helper function.
REQ-028 One sub-module fxp_mul (signed WIDTH x WIDTH, shift by FIXED_POINT_INDEX, optional saturation) is shared by DOT and SCALE; only one instance.

Verification (WIDTH=16, DIMENSION=10, FIXED_POINT_INDEX=8)
REQ-029 y[0]=256, others 0; g = {100,-50,7,...} -> s=100; all grad_out=0; done after edge 21.
REQ-030 y[0]=y[1]=128, others 0; g[0]=256, others 0 -> s=128; grad_out[0]=64, grad_out[1]=-64, rest 0.
REQ-031 y[0]=512, g[0]=-32768, y[1]=256, g[1]=32767, rest 0 -> s saturates to -32768; grad_out[1]=32767, grad_out[0]=0.
REQ-032 Reset asserted at cycle 15 (during SCALE) -> busy=0, done=0, grad_out all 0 immediately; no done pulse follows.
REQ-033 start held high continuously for three operations -> exactly three done pulses, 22 cycles apart; start pulses while busy ignored.
REQ-034 Change y_data/grad_in one cycle after start -> grad_out matches values latched at start.
